// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types and helpers for the planar video shifter.
//   state_e        : line state machine encoding (exposed on the debug port)
//   MODE_*         : encodings of the 2-bit plane-count mode input
//   planes_active  : active plane count for a mode, clamped to the physical
//                    number of plane shift registers
// -----------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] MODE_1P = 2'd0;
  localparam logic [1:0] MODE_2P = 2'd1;
  localparam logic [1:0] MODE_4P = 2'd2;
  localparam logic [1:0] MODE_8P = 2'd3;

  function automatic int unsigned planes_active(input logic [1:0] mode,
                                                input int unsigned planes);
    int unsigned req;
    case (mode)
      MODE_1P: req = 1;
      MODE_2P: req = 2;
      MODE_4P: req = 4;
      MODE_8P: req = 8;
      default: req = 1;
    endcase
    return (req < planes) ? req : planes;
  endfunction

endpackage

// File: rtl/shifter_plane_reg.sv
// -----------------------------------------------------------------------------
// shifter_plane_reg
// One bitplane shift register. A parallel load takes priority over shifting;
// the loaded word is pre-shifted left by shamt_i with zero fill so the first
// visible pixel can start mid-word (fine horizontal scroll).
// Ports:
//   clk_i    : clock, posedge
//   reset_i  : synchronous active-high reset, clears the register
//   load_i   : parallel load of data_i << shamt_i
//   shift_i  : shift left by one, zero in (ignored while load_i is high)
//   data_i   : word to load
//   shamt_i  : pre-shift amount for the load
//   msb_o    : current pixel bit (register MSB)
// -----------------------------------------------------------------------------
module shifter_plane_reg
  import shifter_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int SCROLL_W = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic [WORD_W-1:0]   data_i,
  input  logic [SCROLL_W-1:0] shamt_i,
  output logic                msb_o
);

  logic [WORD_W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i << shamt_i;
    end else if (shift_i) begin
      sh_d = {sh_q[WORD_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign msb_o = sh_q[WORD_W-1];

endmodule

// File: rtl/shifter_video_planar.sv
// -----------------------------------------------------------------------------
// shifter_video_planar
// Bitplane video shifter. Plane words arriving on the DMA stream are collected
// into a group buffer; every WORD_W pixels the buffer is transferred into a
// bank of per-plane shift registers, which then emit one colour index per
// pixel enable. Line parameters (plane count, fine scroll) are latched at the
// rising edge of de.
//
// Optional build macro: SHIFTER_BORDER_COLOR_EN adds input border_idx, which
// is shown instead of 0 whenever no fetched pixel data is on the output.
//
// Ports:
//   clk32        : system clock, posedge
//   reset        : synchronous active-high reset
//   pix_en       : one-cycle pixel enable
//   de           : display enable
//   load, din    : word strobe and plane word (plane 0 first in a group).
//                  load is a plain one-cycle strobe with no backpressure: a
//                  word offered while the buffer is full (and not being
//                  emptied that cycle) is dropped and flagged as overrun.
//   mode         : active planes 0=1,1=2,2=4,3=8 (clamped to PLANES)
//   hscroll      : fine scroll in pixels
//   border_idx   : border colour (only with SHIFTER_BORDER_COLOR_EN)
//   reload       : pulse with the shift-register transfer from the buffer
//   pix_valid    : colour index carries fetched pixel data
//   color_index  : register MSBs, inactive planes forced to 0
//   underrun     : sticky, group boundary reached with buffer incomplete
//   overrun      : sticky, word dropped because the buffer was full
//   dbg_state_o  : current line state (state_e encoding)
// -----------------------------------------------------------------------------
module shifter_video_planar
  import shifter_pkg::*;
#(
  parameter int PLANES   = 4,
  parameter int WORD_W   = 16,
  parameter int SCROLL_W = 4
) (
  input  logic                clk32,
  input  logic                reset,
  input  logic                pix_en,
  input  logic                de,
  input  logic                load,
  input  logic [WORD_W-1:0]   din,
  input  logic [1:0]          mode,
  input  logic [SCROLL_W-1:0] hscroll,
`ifdef SHIFTER_BORDER_COLOR_EN
  input  logic [PLANES-1:0]   border_idx,
`endif
  output logic                reload,
  output logic                pix_valid,
  output logic [PLANES-1:0]   color_index,
  output logic                underrun,
  output logic                overrun,
  output logic [1:0]          dbg_state_o
);

  localparam int CNT_W = $clog2(PLANES + 1);
  localparam logic [SCROLL_W-1:0] PCNT_LAST = SCROLL_W'(WORD_W - 1);

  state_e              state_q, state_d;
  logic                de_q;
  logic [CNT_W-1:0]    wcnt_q, wcnt_d;
  logic [CNT_W-1:0]    pact_q, pact_d;
  logic [SCROLL_W-1:0] scroll_q, scroll_d;
  logic [SCROLL_W-1:0] pcnt_q, pcnt_d;
  logic [WORD_W-1:0]   buf_q [PLANES];
  logic [WORD_W-1:0]   buf_d [PLANES];
  logic                reload_q, reload_d;
  logic                valid_q, valid_d;
  logic                under_q, under_d;
  logic                over_q, over_d;

  logic                de_rise;
  logic                buf_full;
  logic                at_last;
  logic                do_reload;   // buffer -> shift registers
  logic                do_zero;     // underrun: shift registers <- 0
  logic                do_shift;
  logic                load_ok;
  logic [SCROLL_W-1:0] pre_shift;
  logic [PLANES-1:0]   msb;
  logic [PLANES-1:0]   act_mask;
  logic [PLANES-1:0]   idle_color;

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    de_rise   = de && !de_q;
    buf_full  = (wcnt_q == pact_q);
    at_last   = pix_en && (pcnt_q == PCNT_LAST);

    do_reload = 1'b0;
    do_zero   = 1'b0;
    do_shift  = 1'b0;
    load_ok   = 1'b0;
    pre_shift = '0;

    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pact_d    = pact_q;
    scroll_d  = scroll_q;
    pcnt_d    = pcnt_q;
    buf_d     = buf_q;
    reload_d  = 1'b0;
    valid_d   = valid_q;
    under_d   = under_q;
    over_d    = over_q;

    unique case (state_q)
      ST_IDLE: begin
        if (de_rise) begin
          state_d  = ST_FILL;
          wcnt_d   = '0;
          under_d  = 1'b0;
          over_d   = 1'b0;
          pact_d   = CNT_W'(planes_active(mode, PLANES));
          scroll_d = hscroll;
        end
      end
      ST_FILL: begin
        load_ok = de;
        if (!de) begin
          state_d = ST_IDLE;
        end else if (pix_en && buf_full) begin
          // First group of the line enters pre-shifted by the fine scroll,
          // so the pixel counter starts at the scroll value as well.
          do_reload = 1'b1;
          pre_shift = scroll_q;
          pcnt_d    = scroll_q;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        load_ok = 1'b1;
        if (at_last) begin
          if (buf_full) begin
            do_reload = 1'b1;
          end else begin
            do_zero = 1'b1;
          end
          pcnt_d = '0;
        end else if (pix_en) begin
          do_shift = 1'b1;
          pcnt_d   = pcnt_q + 1'b1;
        end
        // A boundary reload in the same cycle still completes.
        if (!de) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pix_en) begin
          do_shift = 1'b1;
          pcnt_d   = pcnt_q + 1'b1;
          if (pcnt_q == PCNT_LAST) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_reload) begin
      reload_d = 1'b1;
      valid_d  = 1'b1;
      wcnt_d   = '0;
    end
    // Partial buffer contents are kept on underrun so a late word can still
    // complete the group for the following boundary.
    if (do_zero) begin
      valid_d = 1'b0;
      under_d = 1'b1;
    end

    if (load && load_ok) begin
      if (do_reload) begin
        buf_d[0] = din;
        wcnt_d   = CNT_W'(1);
      end else if (buf_full) begin
        over_d = 1'b1;
      end else begin
        for (int p = 0; p < PLANES; p++) begin
          if (wcnt_q == CNT_W'(p)) begin
            buf_d[p] = din;
          end
        end
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk32) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      de_q     <= 1'b0;
      wcnt_q   <= '0;
      pact_q   <= '0;
      scroll_q <= '0;
      pcnt_q   <= '0;
      reload_q <= 1'b0;
      valid_q  <= 1'b0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
      for (int p = 0; p < PLANES; p++) begin
        buf_q[p] <= '0;
      end
    end else begin
      state_q  <= state_d;
      de_q     <= de;
      wcnt_q   <= wcnt_d;
      pact_q   <= pact_d;
      scroll_q <= scroll_d;
      pcnt_q   <= pcnt_d;
      reload_q <= reload_d;
      valid_q  <= valid_d;
      under_q  <= under_d;
      over_q   <= over_d;
      for (int p = 0; p < PLANES; p++) begin
        buf_q[p] <= buf_d[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Plane shift registers
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < PLANES; g++) begin : g_plane
    shifter_plane_reg #(
      .WORD_W   (WORD_W),
      .SCROLL_W (SCROLL_W)
    ) u_reg (
      .clk_i   (clk32),
      .reset_i (reset),
      .load_i  (do_reload | do_zero),
      .shift_i (do_shift),
      .data_i  (do_zero ? '0 : buf_q[g]),
      .shamt_i (pre_shift),
      .msb_o   (msb[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
`ifdef SHIFTER_BORDER_COLOR_EN
  assign idle_color = border_idx;
`else
  assign idle_color = '0;
`endif

  always_comb begin
    for (int p = 0; p < PLANES; p++) begin
      act_mask[p] = (CNT_W'(p) < pact_q);
    end
    color_index = valid_q ? (msb & act_mask) : idle_color;
  end

  assign reload      = reload_q;
  assign pix_valid   = valid_q;
  assign underrun    = under_q;
  assign overrun     = over_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shifter_video_planar.sv
// -----------------------------------------------------------------------------
// tb_shifter_video_planar
// Directed + randomized line sequences. The reference is the pixel stream of a
// line: pixel i of a group on plane p is bit (WORD_W-1-i) of that group's word
// for plane p, with the first group starting at the fine-scroll pixel.
// -----------------------------------------------------------------------------
module tb_shifter_video_planar;
  import shifter_pkg::*;

  localparam int PLANES   = 4;
  localparam int WORD_W   = 16;
  localparam int SCROLL_W = 4;
  localparam int GMAX     = 4;

  logic                clk32 = 1'b0;
  logic                reset;
  logic                pix_en;
  logic                de;
  logic                load;
  logic [WORD_W-1:0]   din;
  logic [1:0]          mode;
  logic [SCROLL_W-1:0] hscroll;
`ifdef SHIFTER_BORDER_COLOR_EN
  logic [PLANES-1:0]   border_idx;
`endif
  logic                reload;
  logic                pix_valid;
  logic [PLANES-1:0]   color_index;
  logic                underrun;
  logic                overrun;
  logic [1:0]          dbg_state;

  int n_pass   = 0;
  int n_checks = 0;
  int n_fail   = 0;

  logic [PLANES-1:0] exp_q[$];
  logic [WORD_W-1:0] grp_w [GMAX][PLANES];
  logic [PLANES-1:0] idle_exp;

  shifter_video_planar #(
    .PLANES   (PLANES),
    .WORD_W   (WORD_W),
    .SCROLL_W (SCROLL_W)
  ) dut (
    .clk32       (clk32),
    .reset       (reset),
    .pix_en      (pix_en),
    .de          (de),
    .load        (load),
    .din         (din),
    .mode        (mode),
    .hscroll     (hscroll),
`ifdef SHIFTER_BORDER_COLOR_EN
    .border_idx  (border_idx),
`endif
    .reload      (reload),
    .pix_valid   (pix_valid),
    .color_index (color_index),
    .underrun    (underrun),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  always #5 clk32 = ~clk32;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, pass the active edge, land 1 time unit after it.
  task automatic step(input logic pe, input logic ld, input logic [WORD_W-1:0] w);
    pix_en = pe;
    load   = ld;
    din    = w;
    @(posedge clk32);
    #1;
    pix_en = 1'b0;
    load   = 1'b0;
  endtask

  function automatic int plane_count(input logic [1:0] md);
    int n;
    n = 1 << md;
    if (n > PLANES) n = PLANES;
    return n;
  endfunction

  function automatic logic [PLANES-1:0] pix_of(input int g, input int i, input int pact);
    logic [PLANES-1:0] c;
    c = '0;
    for (int p = 0; p < PLANES; p++) begin
      if (p < pact) c[p] = grp_w[g][p][WORD_W-1-i];
    end
    return c;
  endfunction

  task automatic rand_groups();
    for (int g = 0; g < GMAX; g++)
      for (int p = 0; p < PLANES; p++)
        grp_w[g][p] = 16'($urandom);
  endtask

  // Full line: ng groups, de dropped after pixel 7 of the last group.
  task automatic run_line(input logic [1:0] md, input logic [SCROLL_W-1:0] sc, input int ng);
    int pact;
    int start;
    int nxt;
    pact    = plane_count(md);
    mode    = md;
    hscroll = sc;
    exp_q.delete();
    for (int g = 0; g < ng; g++) begin
      start = (g == 0) ? int'(sc) : 0;
      for (int i = start; i < WORD_W; i++) exp_q.push_back(pix_of(g, i, pact));
    end
    de = 1'b1;
    step(1'b0, 1'b0, '0);
    check("line_fill_state", dbg_state, ST_FILL);
    check("line_flags_clear", {underrun, overrun}, 2'b00);
    for (int p = 0; p < pact; p++) step(1'b0, 1'b1, grp_w[0][p]);
    mode    = ~md;
    hscroll = ~sc;
    check("fill_color", color_index, idle_exp);
    check("fill_valid", pix_valid, 1'b0);
    for (int g = 0; g < ng; g++) begin
      start = (g == 0) ? int'(sc) : 0;
      nxt   = 0;
      for (int i = start; i < WORD_W; i++) begin
        step(1'b1, 1'b0, '0);
        check("line_pixel", color_index, exp_q.pop_front());
        check("line_reload", reload, i == start);
        check("line_valid", pix_valid, 1'b1);
        if (g == ng - 1) begin
          if (i == 7) begin
            de = 1'b0;
            step(1'b0, 1'b0, '0);
            check("drain_state", dbg_state, ST_DRAIN);
          end
        end else begin
          if (nxt < pact) begin
            step(1'b0, 1'b1, grp_w[g+1][nxt]);
            nxt++;
          end
          if (i == WORD_W - 1) begin
            while (nxt < pact) begin
              step(1'b0, 1'b1, grp_w[g+1][nxt]);
              nxt++;
            end
          end
        end
      end
    end
    step(1'b1, 1'b0, '0);
    check("end_state_idle", dbg_state, ST_IDLE);
    check("end_valid", pix_valid, 1'b0);
    check("end_color", color_index, idle_exp);
    check("end_reload", reload, 1'b0);
    check("end_flags", {underrun, overrun}, 2'b00);
    step(1'b0, 1'b0, '0);
  endtask

  initial begin
    reset   = 1'b1;
    pix_en  = 1'b0;
    de      = 1'b0;
    load    = 1'b0;
    din     = '0;
    mode    = 2'd2;
    hscroll = '0;
`ifdef SHIFTER_BORDER_COLOR_EN
    border_idx = 4'hA;
    idle_exp   = 4'hA;
`else
    idle_exp   = 4'h0;
`endif
    repeat (3) @(posedge clk32);
    #1;
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_outputs", {reload, pix_valid, underrun, overrun}, 4'b0000);
    check("reset_color", color_index, idle_exp);
    reset = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 16'hFFFF);
    check("idle_load_ignored", dbg_state, ST_IDLE);

    // single lit pixel on plane 0
    rand_groups();
    grp_w[0][0] = 16'h8000;
    grp_w[0][1] = 16'h0000;
    grp_w[0][2] = 16'h0000;
    grp_w[0][3] = 16'h0000;
    run_line(2'd2, 4'd0, 3);

    // one plane, scroll 5, all-ones word
    rand_groups();
    grp_w[0][0] = 16'hFFFF;
    run_line(2'd0, 4'd5, 2);

    // randomized lines, including the clamped 8-plane mode
    for (int r = 0; r < 6; r++) begin
      rand_groups();
      run_line(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(2, 3)));
    end

    // underrun: 4th word of group 1 withheld until after the boundary
    rand_groups();
    mode = 2'd2;
    hscroll = '0;
    de = 1'b1;
    step(1'b0, 1'b0, '0);
    for (int p = 0; p < 4; p++) step(1'b0, 1'b1, grp_w[0][p]);
    step(1'b1, 1'b0, '0);
    check("ur_first_pixel", color_index, pix_of(0, 0, 4));
    for (int i = 1; i < WORD_W; i++) begin
      if (i <= 3) step(1'b0, 1'b1, grp_w[1][i-1]);
      else step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      check("ur_g0_pixel", color_index, pix_of(0, i, 4));
    end
    step(1'b1, 1'b0, '0);
    check("ur_flag", underrun, 1'b1);
    check("ur_valid", pix_valid, 1'b0);
    check("ur_color", color_index, idle_exp);
    check("ur_no_reload", reload, 1'b0);
    for (int i = 1; i < WORD_W; i++) begin
      step(1'b0, (i == 1), grp_w[1][3]);
      step(1'b1, 1'b0, '0);
      check("ur_hold_color", color_index, idle_exp);
      check("ur_hold_valid", pix_valid, 1'b0);
    end
    step(1'b1, 1'b0, '0);
    check("ur_restore_valid", pix_valid, 1'b1);
    check("ur_restore_pixel", color_index, pix_of(1, 0, 4));
    check("ur_restore_reload", reload, 1'b1);
    check("ur_sticky", underrun, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, '0);
      check("ur_g1_pixel", color_index, pix_of(1, i, 4));
    end
    de = 1'b0;
    step(1'b0, 1'b0, '0);
    repeat (9) step(1'b1, 1'b0, '0);
    check("ur_idle_state", dbg_state, ST_IDLE);
    check("ur_sticky_idle", underrun, 1'b1);
    de = 1'b1;
    step(1'b0, 1'b0, '0);
    check("ur_clear_on_rise", underrun, 1'b0);
    check("ur_fill_color", color_index, idle_exp);
    de = 1'b0;
    step(1'b0, 1'b0, '0);
    check("fill_de_fall_idle", dbg_state, ST_IDLE);

    // overrun: load on reload cycle lands in slot 0; extra load is dropped
    rand_groups();
    grp_w[2][0] = ~grp_w[1][0];
    de = 1'b1;
    step(1'b0, 1'b0, '0);
    for (int p = 0; p < 4; p++) step(1'b0, 1'b1, grp_w[0][p]);
    step(1'b1, 1'b1, grp_w[1][0]);
    check("ov_reload_load", reload, 1'b1);
    check("ov_none_on_reload", overrun, 1'b0);
    check("ov_first_pixel", color_index, pix_of(0, 0, 4));
    for (int i = 1; i < WORD_W; i++) begin
      if (i <= 3) step(1'b0, 1'b1, grp_w[1][i]);
      else if (i == 5) step(1'b0, 1'b1, grp_w[2][0]);
      else step(1'b0, 1'b0, '0);
      if (i == 4) check("ov_not_yet", overrun, 1'b0);
      if (i == 5) check("ov_set", overrun, 1'b1);
      step(1'b1, 1'b0, '0);
      check("ov_g0_pixel", color_index, pix_of(0, i, 4));
    end
    for (int i = 0; i < WORD_W; i++) begin
      step(1'b1, 1'b0, '0);
      check("ov_g1_pixel", color_index, pix_of(1, i, 4));
      if (i == 0) check("ov_g1_reload", reload, 1'b1);
    end

    // reset mid-RUN
    reset = 1'b1;
    step(1'b0, 1'b0, '0);
    check("rst_run_state", dbg_state, ST_IDLE);
    check("rst_run_outputs", {reload, pix_valid, underrun, overrun}, 4'b0000);
    check("rst_run_color", color_index, idle_exp);
    reset = 1'b0;
    de    = 1'b0;
    step(1'b0, 1'b0, '0);
    check("post_rst_idle", dbg_state, ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
